imm_encoder: RTL

//  Inverse of the immediate decoder: packs a 32-bit immediate into RISC-V instruction bit positions by type.

---
 rtl/imm_encoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Packs immediates into RISC-V instruction bit positions and expands LI into ADDI or LUI(+ADDI).
// Optional macro IMM_RANGE_CHECK_EN flags immediates that the selected format cannot represent.
module imm_encoder #(
  parameter logic [6:0] LUI_OPC  = 7'b0110111,
  parameter logic [6:0] ADDI_OPC = 7'b0010011
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] imm_i,
  input  logic [2:0]  imm_sel_i,
  input  logic [4:0]  rd_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic        last_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_SECOND, S_ADDI} state_t;

  state_t      state_q, state_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic        last_q, last_d;
  logic [11:0] lo_q, lo_d;
  logic [4:0]  rd_q, rd_d;

  logic        accept, take, load_addi;
  logic [31:0] enc_word;
  logic        enc_last, enc_two;
  logic        li_small;
  logic [19:0] li_hi;

  assign req_ready_o = (state_q == S_IDLE) && (!inst_valid_q || inst_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign take        = inst_valid_q && inst_ready_i;
  assign load_addi   = (state_q == S_SECOND) && take;

  // The upper half is rounded up when the low 12 bits will be sign-extended negative by ADDI.
  assign li_small = (imm_i[31:11] == {21{imm_i[11]}});
  assign li_hi    = imm_i[31:12] + {19'b0, imm_i[11]};

  always_comb begin
    enc_word = '0;
    enc_last = 1'b1;
    enc_two  = 1'b0;
    case (imm_sel_i)
      3'b001: enc_word[31:20] = imm_i[11:0];
      3'b010: begin
        enc_word[31:25] = imm_i[11:5];
        enc_word[11:7]  = imm_i[4:0];
      end
      3'b011: begin
        enc_word[31]    = imm_i[12];
        enc_word[30:25] = imm_i[10:5];
        enc_word[11:8]  = imm_i[4:1];
        enc_word[7]     = imm_i[11];
      end
      3'b100: enc_word[31:12] = imm_i[31:12];
      3'b101: begin
        enc_word[31]    = imm_i[20];
        enc_word[30:21] = imm_i[10:1];
        enc_word[20]    = imm_i[11];
        enc_word[19:12] = imm_i[19:12];
      end
      3'b110: begin
        if (li_small) begin
          enc_word = {imm_i[11:0], 5'd0, 3'b000, rd_i, ADDI_OPC};
        end else begin
          enc_word = {li_hi, rd_i, LUI_OPC};
          enc_two  = (imm_i[11:0] != 12'd0);
          enc_last = !enc_two;
        end
      end
      default: enc_word = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && enc_two) state_d = S_SECOND;
      S_SECOND: if (take) state_d = S_ADDI;
      S_ADDI:   if (take) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A new request or the pending ADDI refills the output word; a bare handshake just empties it.
  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    last_d       = last_q;
    lo_d         = lo_q;
    rd_d         = rd_q;
    if (accept) begin
      inst_valid_d = 1'b1;
      inst_d       = enc_word;
      last_d       = enc_last;
      lo_d         = imm_i[11:0];
      rd_d         = rd_i;
    end else if (load_addi) begin
      inst_valid_d = 1'b1;
      inst_d       = {lo_q, rd_q, 3'b000, rd_q, ADDI_OPC};
      last_d       = 1'b1;
    end else if (take) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      last_q       <= 1'b0;
      lo_q         <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      last_q       <= last_d;
      lo_q         <= lo_d;
      rd_q         <= rd_d;
    end
  end

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign last_o       = last_q;

`ifdef IMM_RANGE_CHECK_EN
  logic err_calc, err_q;

  always_comb begin
    err_calc = 1'b0;
    case (imm_sel_i)
      3'b001, 3'b010: err_calc = (imm_i[31:11] != {21{imm_i[11]}});
      3'b011:         err_calc = imm_i[0] || (imm_i[31:12] != {20{imm_i[12]}});
      3'b100:         err_calc = (imm_i[11:0] != 12'd0);
      3'b101:         err_calc = imm_i[0] || (imm_i[31:20] != {12{imm_i[20]}});
      3'b111:         err_calc = 1'b1;
      default:        err_calc = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= err_calc;
    end else if (load_addi) begin
      err_q <= 1'b0;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
